// File: rtl/i2c_wr_sched.sv
// Round-robin scheduler sharing one I2C write master among N_REQ clients.
// Grants, launches the master, waits for completion/timeout, then forces a bus-free gap.
module i2c_wr_sched #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 nack,
    output logic                 tout,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack
);

    localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              nack_q, nack_d;
    logic              tout_q, tout_d;
    logic              m_start_q, m_start_d;
    logic [6:0]        m_addr_q, m_addr_d;
    logic [7:0]        m_data_q, m_data_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    // Shared between the WAIT timeout and the GAP countdown; never both active.
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              found;
    logic [PW-1:0]     sel;
    logic [6:0]        sel_addr;
    logic [7:0]        sel_data;

    // Round-robin pick: scan ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        found    = 1'b0;
        sel      = '0;
        sel_addr = '0;
        sel_data = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                sel      = PW'(idx);
                sel_addr = req_addr[idx*7 +: 7];
                sel_data = req_data[idx*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        nack_d    = nack_q;
        tout_d    = tout_q;
        m_start_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d    = N_REQ'(1) << sel;
                    m_addr_d = sel_addr;
                    m_data_d = sel_data;
                    ptr_d    = sel;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                if (!m_busy) begin
                    m_start_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                // m_done is checked first so it wins over a same-cycle timeout.
                if (m_done) begin
                    done_d  = gnt_q;
                    nack_d  = m_nack;
                    tout_d  = 1'b0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    done_d  = gnt_q;
                    nack_d  = 1'b0;
                    tout_d  = 1'b1;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StGap: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            done_q    <= '0;
            nack_q    <= 1'b0;
            tout_q    <= 1'b0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            ptr_q     <= PW'(N_REQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            tout_q    <= tout_d;
            m_start_q <= m_start_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign nack    = nack_q;
    assign tout    = tout_q;
    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_i2c_wr_sched.sv
// Scoreboard bench for i2c_wr_sched: stimulus pushes expected launches/completions,
// a negedge monitor pops and compares whenever m_start or done is presented.
module tb_i2c_wr_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 4;
    localparam int unsigned TO  = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = '0;
    logic [27:0]  req_addr;
    logic [31:0]  req_data;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic         nack;
    logic         tout;
    logic         m_start;
    logic [6:0]   m_addr;
    logic [7:0]   m_data;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_nack = 1'b0;

    i2c_wr_sched #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .nack     (nack),
        .tout     (tout),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_busy   (m_busy),
        .m_done   (m_done),
        .m_nack   (m_nack)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] g; logic [6:0] a; logic [7:0] d;} launch_t;
    typedef struct packed {logic [3:0] dn; logic nk; logic to;} resp_t;

    launch_t launch_q[$];
    resp_t   resp_q[$];
    int      gnt_cycs[$];
    int      done_cycs[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   gnt_cyc = 0;
    logic [3:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_l(input logic [3:0] g, input logic [6:0] a, input logic [7:0] d);
        launch_q.push_back('{g: g, a: a, d: d});
    endtask

    task automatic push_r(input logic [3:0] dn, input logic nk, input logic to);
        resp_q.push_back('{dn: dn, nk: nk, to: to});
    endtask

    // Monitor: compares every presented launch and completion against the queues.
    always @(negedge clk) begin
        launch_t el;
        resp_t   er;
        if (rst) begin
            if (m_start === 1'b1) begin
                start_cyc = cyc;
                if (launch_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_m_start gnt=%b addr=%h (cycle %0d)", gnt, m_addr, cyc);
                end else begin
                    el = launch_q.pop_front();
                    chk("launch_gnt", 32'(gnt), 32'(el.g));
                    chk("launch_addr", 32'(m_addr), 32'(el.a));
                    chk("launch_data", 32'(m_data), 32'(el.d));
                end
            end
            if (done !== 4'b0000) begin
                done_cyc = cyc;
                done_cycs.push_back(cyc);
                if (resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done done=%b (cycle %0d)", done, cyc);
                end else begin
                    er = resp_q.pop_front();
                    chk("resp_done", 32'(done), 32'(er.dn));
                    chk("resp_nack", 32'(nack), 32'(er.nk));
                    chk("resp_tout", 32'(tout), 32'(er.to));
                end
            end
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                gnt_cyc = cyc;
                gnt_cycs.push_back(cyc);
            end
        end
        prev_gnt = gnt;
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_m_start actual=timeout expected=m_start within 200 cycles");
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=timeout expected=done within 200 cycles");
        end
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_gnt actual=timeout expected=grant within 50 cycles");
        end
    endtask

    // Master model: waits for launch, answers after lat cycles with a one-cycle m_done.
    task automatic master_frame(input bit nk, input int lat);
        bit ok;
        wait_start(ok);
        if (ok) begin
            repeat (lat) @(negedge clk);
            m_done = 1'b1;
            m_nack = nk;
            @(negedge clk);
            m_done = 1'b0;
            m_nack = 1'b0;
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit ok;
        int k;
        #100000;
        $display("FAIL watchdog actual=no finish expected=finish before 100us");
        $fatal(1);
    end

    initial begin
        bit ok;
        int k;
        req_addr = {7'h43, 7'h32, 7'h21, 7'h1A};
        req_data = {8'h88, 8'h77, 8'h66, 8'h55};

        // Reset values
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_nack", 32'(nack), 0);
        chk("rst_tout", 32'(tout), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_data", 32'(m_data), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame, grant one clk after req, launch the clk after that
        #1;
        k = cyc;
        req = 4'b0001;
        push_l(4'b0001, 7'h1A, 8'h55);
        push_r(4'b0001, 1'b0, 1'b0);
        master_frame(1'b0, 1);
        req = 4'b0000;
        chk("t1_gnt_latency", 32'(gnt_cyc - k), 1);
        chk("t1_start_latency", 32'(start_cyc - k), 2);

        // 2: all four requesting from reset -> 0,1,2,3,0 with exact gap spacing
        do_reset();
        #1;
        gnt_cycs.delete();
        done_cycs.delete();
        req = 4'b1111;
        push_l(4'b0001, 7'h1A, 8'h55);
        push_l(4'b0010, 7'h21, 8'h66);
        push_l(4'b0100, 7'h32, 8'h77);
        push_l(4'b1000, 7'h43, 8'h88);
        push_l(4'b0001, 7'h1A, 8'h55);
        for (int i = 0; i < 5; i++) push_r(4'b0001 << (i % 4), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) master_frame(1'b0, i);
        req = 4'b0000;
        chk("t2_grant_count", 32'(gnt_cycs.size()), 5);
        for (int i = 0; i < 4; i++) begin
            if (i + 1 < gnt_cycs.size() && i < done_cycs.size())
                chk("t2_done_to_gnt", 32'(gnt_cycs[i+1] - done_cycs[i]), GAP + 1);
        end

        // 3: master busy for 10 clk in LAUNCH; address change after grant ignored
        repeat (8) @(negedge clk);
        #1;
        m_busy = 1'b1;
        req = 4'b0100;
        push_l(4'b0100, 7'h32, 8'h77);
        push_r(4'b0100, 1'b0, 1'b0);
        wait_gnt(ok);
        req_addr[14 +: 7] = 7'h7F;
        chk("t3_no_start_busy", 32'(m_start), 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t3_no_start_busy", 32'(m_start), 0);
        end
        #1;
        k = cyc;
        m_busy = 1'b0;
        master_frame(1'b0, 2);
        req = 4'b0000;
        req_addr[14 +: 7] = 7'h32;
        chk("t3_start_after_busy", 32'(start_cyc - k), 1);

        // 4: no m_done -> timeout exactly TO clk after m_start
        repeat (8) @(negedge clk);
        #1;
        req = 4'b1000;
        push_l(4'b1000, 7'h43, 8'h88);
        push_r(4'b1000, 1'b0, 1'b1);
        wait_start(ok);
        wait_done(ok);
        req = 4'b0000;
        chk("t4_timeout_latency", 32'(done_cyc - start_cyc), TO);

        // 5a: NACK reported and held
        repeat (8) @(negedge clk);
        #1;
        req = 4'b0001;
        push_l(4'b0001, 7'h1A, 8'h55);
        push_r(4'b0001, 1'b1, 1'b0);
        master_frame(1'b1, 1);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t5_nack_held", 32'(nack), 1);
        chk("t5_tout_clear", 32'(tout), 0);

        // 5b: good frame clears nack
        repeat (5) @(negedge clk);
        #1;
        req = 4'b0010;
        push_l(4'b0010, 7'h21, 8'h66);
        push_r(4'b0010, 1'b0, 1'b0);
        master_frame(1'b0, 0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t5_nack_cleared", 32'(nack), 0);

        // 5c: m_done lands on the timeout cycle -> completion wins, tout=0
        repeat (5) @(negedge clk);
        #1;
        req = 4'b0100;
        push_l(4'b0100, 7'h32, 8'h77);
        push_r(4'b0100, 1'b0, 1'b0);
        wait_start(ok);
        repeat (TO - 1) @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        #1;
        req = 4'b0000;
        chk("t5_race_latency", 32'(done_cyc - start_cyc), TO);
        chk("t5_race_tout", 32'(tout), 0);

        // 5d: stray m_done while idle must not produce a done pulse
        repeat (10) @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        repeat (3) @(negedge clk);

        // 6: async reset during WAIT, then pointer restarts at client 0
        #1;
        req = 4'b0010;
        push_l(4'b0010, 7'h21, 8'h66);
        wait_start(ok);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_m_start", 32'(m_start), 0);
        chk("t6_rst_m_addr", 32'(m_addr), 0);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        req = 4'b0111;
        push_l(4'b0001, 7'h1A, 8'h55);
        push_l(4'b0010, 7'h21, 8'h66);
        push_l(4'b0100, 7'h32, 8'h77);
        push_r(4'b0001, 1'b0, 1'b0);
        push_r(4'b0010, 1'b0, 1'b0);
        push_r(4'b0100, 1'b0, 1'b0);
        master_frame(1'b0, 0);
        req[0] = 1'b0;
        master_frame(1'b0, 1);
        req[1] = 1'b0;
        master_frame(1'b0, 0);
        req = 4'b0000;

        repeat (10) @(negedge clk);
        chk("end_launch_q_empty", 32'(launch_q.size()), 0);
        chk("end_resp_q_empty", 32'(resp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
